// File: rtl/fpmul_feeder_pkg.sv
// Shared types and constants for the serial-load FP32 multiplier operand feeder.
package fpmul_feeder_pkg;

    typedef enum logic [2:0] {
        RST_HOLD,
        SYNC,
        DRIVE_A,
        DRIVE_B,
        WAIT_RESULT
    } feeder_state_t;

    localparam int unsigned LOAD_A_OFS  = 1;
    localparam int unsigned LOAD_B_OFS  = 2;
    localparam int unsigned NORMAL_LAT  = 7;
    localparam int unsigned SPECIAL_LAT = 6;

    localparam logic [31:0] FP32_ZERO = 32'h0;

endpackage

// File: rtl/fpmul_result_fifo.sv
// Result FIFO: synchronous, registered head, push and pop allowed together at any count.
module fpmul_result_fifo
    import fpmul_feeder_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      left;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        pop_ok  = pop && (count != '0);
        push_ok = push && ((count != (AW+1)'(DEPTH)) || pop_ok);
        rd_next = rd_ptr + AW'(pop_ok);
        left    = count - (AW+1)'(pop_ok);
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is refreshed from the bypass path when the FIFO would otherwise be empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            rd_ptr <= rd_next;
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= left + (AW+1)'(push_ok);
            if (left == '0) begin
                if (push_ok) begin
                    head <= push_data;
                end
            end else begin
                head <= mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/fpmul_operand_feeder.sv
// Serialises operand pairs onto the multiplier's shared operand bus, owns its reset,
// captures products into an in-order result FIFO and recovers via a watchdog.
module fpmul_operand_feeder
    import fpmul_feeder_pkg::*;
#(
    parameter int unsigned RES_DEPTH  = 4,
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_product,
    output logic        mul_nreset,
    output logic [31:0] mul_operand,
    input  logic [31:0] mul_product,
    input  logic        mul_ready,
    output logic        error,
    output logic [7:0]  drop_count
);

    localparam int unsigned CW = $clog2(RES_DEPTH) + 1;
    localparam int unsigned WW = $clog2(TIMEOUT + 1);
    localparam int unsigned RW = $clog2(RST_CYCLES + 1);

    feeder_state_t state;
    feeder_state_t state_next;

    logic          live;
    logic          hold_full;
    logic [31:0]   hold_a;
    logic [31:0]   hold_b;
    logic          slot_real;
    logic [31:0]   slot_b;
    logic [WW-1:0] wd_cnt;
    logic [RW-1:0] rst_cnt;

    logic          decide;
    logic          fire;
    logic          take;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occ_next;

    assign in_ready  = live & ~hold_full;
    assign out_valid = (fifo_count != '0);

    always_comb begin
        state_next = state;
        decide     = 1'b0;
        fire       = 1'b0;
        case (state)
            RST_HOLD: begin
                if (rst_cnt == '0) begin
                    state_next = SYNC;
                end
            end
            SYNC: begin
                decide     = 1'b1;
                state_next = DRIVE_A;
            end
            DRIVE_A: begin
                if (mul_ready) begin
                    fire = 1'b1;
                end else begin
                    state_next = DRIVE_B;
                end
            end
            DRIVE_B: begin
                if (mul_ready) begin
                    fire = 1'b1;
                end else begin
                    state_next = WAIT_RESULT;
                end
            end
            WAIT_RESULT: begin
                if (mul_ready) begin
                    decide     = 1'b1;
                    state_next = DRIVE_A;
                end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
                    fire = 1'b1;
                end
            end
            default: state_next = RST_HOLD;
        endcase
        if (fire) begin
            state_next = RST_HOLD;
        end

        push = (state == WAIT_RESULT) && mul_ready && slot_real;
        pop  = out_valid && out_ready;
        // The slot's result lands at the next decision, so room must account for this cycle's push as well.
        occ_next = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(pop);
        take     = decide && hold_full && (occ_next < (CW+1)'(RES_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RST_HOLD;
            live        <= 1'b0;
            hold_full   <= 1'b0;
            hold_a      <= '0;
            hold_b      <= '0;
            slot_real   <= 1'b0;
            slot_b      <= '0;
            wd_cnt      <= '0;
            rst_cnt     <= '0;
            error       <= 1'b0;
            drop_count  <= '0;
            mul_operand <= '0;
            mul_nreset  <= 1'b0;
        end else begin
            state <= state_next;
            live  <= 1'b1;

            if (in_valid && in_ready) begin
                hold_full <= 1'b1;
                hold_a    <= in_a;
                hold_b    <= in_b;
            end else if (take) begin
                hold_full <= 1'b0;
            end

            if (state == RST_HOLD) begin
                if (rst_cnt == '0) begin
                    mul_nreset <= 1'b1;
                end else begin
                    rst_cnt <= rst_cnt - RW'(1);
                end
            end

            if (decide) begin
                slot_real   <= take;
                slot_b      <= take ? hold_b : FP32_ZERO;
                mul_operand <= take ? hold_a : FP32_ZERO;
            end

            if (state == DRIVE_A) begin
                mul_operand <= slot_b;
            end

            if (state == DRIVE_B) begin
                mul_operand <= FP32_ZERO;
                wd_cnt      <= '0;
            end

            if ((state == WAIT_RESULT) && !mul_ready) begin
                wd_cnt <= wd_cnt + WW'(1);
            end

            if (fire) begin
                error       <= 1'b1;
                if (slot_real && (drop_count != 8'hFF)) begin
                    drop_count <= drop_count + 8'd1;
                end
                slot_real   <= 1'b0;
                mul_operand <= FP32_ZERO;
                mul_nreset  <= 1'b0;
                rst_cnt     <= RW'(RST_CYCLES - 1);
            end
        end
    end

    fpmul_result_fifo #(
        .DEPTH(RES_DEPTH),
        .WIDTH(32)
    ) u_result_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (mul_product),
        .pop       (pop),
        .head      (out_product),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_fpmul_operand_feeder.sv
// Directed bench for fpmul_operand_feeder with a cycle-level model of the serial-load multiplier.
module tb_fpmul_operand_feeder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] p;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_product;
    logic        mul_nreset;
    logic [31:0] mul_operand;
    logic [31:0] mul_product;
    logic        mul_ready;
    logic        error;
    logic [7:0]  drop_count;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vec_t        iss_q[$];
    logic [31:0] out_q[$];
    vec_t        tbl[8];

    fpmul_operand_feeder #(
        .RES_DEPTH (4),
        .TIMEOUT   (15),
        .RST_CYCLES(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .mul_nreset  (mul_nreset),
        .mul_operand (mul_operand),
        .mul_product (mul_product),
        .mul_ready   (mul_ready),
        .error       (error),
        .drop_count  (drop_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier model: start cycle at mcyc 0, samples A at end of mcyc 1 and B at end of mcyc 2.
    int          mcyc = 0;
    logic        armed = 1'b0;
    int          lat = 7;
    logic        mute = 1'b0;
    logic [31:0] cap_a = '0;
    logic [31:0] prod = '0;
    int          issue_cnt = 0;
    int          last_issue = 0;
    logic        idle_mode = 1'b0;
    int          prev_bub = -1;
    int          idle_caps = 0;
    int          idle_bad = 0;
    int          idle_op_bad = 0;
    int          idle_ov_bad = 0;
    logic        stale_mode = 1'b0;
    int          stale_cnt = 0;

    assign mul_ready   = armed && !mute && (mcyc == lat);
    assign mul_product = prod;

    function automatic logic special(input logic [31:0] x);
        return (x[30:23] == 8'hFF) || (x[30:0] == 31'h0);
    endfunction

    always @(posedge clock) begin
        vec_t e;
        if (!mul_nreset) begin
            mcyc  <= 0;
            armed <= 1'b0;
        end else begin
            if (mcyc == 1) cap_a <= mul_operand;
            if (mcyc == 2) begin
                armed <= 1'b1;
                lat   <= (special(cap_a) || special(mul_operand)) ? 6 : 7;
                if (cap_a == 32'h0 && mul_operand == 32'h0) begin
                    prod <= 32'hDEADBEEF;
                    if (idle_mode) begin
                        if (prev_bub >= 0 && (cyc - 2 - prev_bub) != 6) idle_bad <= idle_bad + 1;
                        prev_bub  <= cyc - 2;
                        idle_caps <= idle_caps + 1;
                    end
                end else if (iss_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL issue_unexpected: got %h x %h, none expected", cap_a, mul_operand);
                    prod <= 32'hBAD0BAD0;
                end else begin
                    e = iss_q.pop_front();
                    check("issue_a", cap_a, e.a);
                    check("issue_b", mul_operand, e.b);
                    prod       <= e.p;
                    issue_cnt  <= issue_cnt + 1;
                    last_issue <= cyc - 2;
                end
            end
            if (armed && !mute && mcyc == lat) mcyc <= 1;
            else mcyc <= mcyc + 1;
        end
    end

    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (out_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL out_unexpected: got %h, none expected", out_product);
            end else begin
                check("out_product", out_product, out_q.pop_front());
            end
        end
        if (idle_mode) begin
            if (mul_operand != 32'h0) idle_op_bad++;
            if (out_valid) idle_ov_bad++;
        end
        if (stale_mode && out_valid) stale_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic at_cycle(input int t);
        @(negedge clock);
        while (cyc < t) @(negedge clock);
        if (cyc != t) begin
            n_vec++;
            n_err++;
            $display("FAIL at_cycle: got cycle %0d expected %0d", cyc, t);
        end
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] p, input bit want_out);
        int k = 0;
        iss_q.push_back('{a, b, p});
        if (want_out) out_q.push_back(p);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        while (!in_ready && k < 300) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready got 0 expected 1 for %h x %h", a, b);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_issue(input int n0);
        int k = 0;
        while (issue_cnt == n0 && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (issue_cnt == n0) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: issue count got %0d expected %0d", issue_cnt, n0 + 1);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (out_q.size() != 0 && k < 600) begin
            @(negedge clock);
            k++;
        end
        check("drain_remaining", out_q.size(), 0);
    endtask

    logic [31:0] kval[6];

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation got past time limit");
        $fatal(1, "global timeout");
    end

    initial begin
        int d;
        int n0;
        int k;

        tbl[0] = '{32'h40000000, 32'h40400000, 32'h40C00000};
        tbl[1] = '{32'h7F800000, 32'h00000000, 32'h7F800001};
        tbl[2] = '{32'h3F800000, 32'hBF800000, 32'hBF800000};
        tbl[3] = '{32'h40490FDB, 32'h3F800000, 32'h40490FDB};
        tbl[4] = '{32'h3FC00000, 32'h3FC00000, 32'h40100000};
        tbl[5] = '{32'hC0000000, 32'h40A00000, 32'hC1200000};
        tbl[6] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000};
        tbl[7] = '{32'h00000000, 32'h40400000, 32'h00000000};
        kval[0] = 32'h40000000;
        kval[1] = 32'h40400000;
        kval[2] = 32'h40800000;
        kval[3] = 32'h40A00000;
        kval[4] = 32'h40C00000;
        kval[5] = 32'h40E00000;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_nreset", mul_nreset, 0);
        check("rst_mul_operand", mul_operand, 0);
        check("rst_error", error, 0);
        check("rst_drop_count", drop_count, 0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("hold_in_ready", in_ready, 0);
        check("hold_mul_nreset", mul_nreset, 0);
        @(negedge clock);
        check("sync_in_ready", in_ready, 1);
        check("sync_mul_nreset", mul_nreset, 1);

        // 2.0 x 3.0: result at D+8
        n0 = issue_cnt;
        send(tbl[0].a, tbl[0].b, tbl[0].p, 1'b1);
        wait_issue(n0);
        d = last_issue;
        at_cycle(d + 7);
        check("lat_norm_d7_valid", out_valid, 0);
        at_cycle(d + 8);
        check("lat_norm_d8_valid", out_valid, 1);
        check("lat_norm_d8_product", out_product, tbl[0].p);
        drain();

        // Inf x 0: fast path, result at D+7
        n0 = issue_cnt;
        send(tbl[1].a, tbl[1].b, tbl[1].p, 1'b1);
        wait_issue(n0);
        d = last_issue;
        at_cycle(d + 6);
        check("lat_spec_d6_valid", out_valid, 0);
        at_cycle(d + 7);
        check("lat_spec_d7_valid", out_valid, 1);
        check("lat_spec_d7_product", out_product, tbl[1].p);
        drain();
        check("spec_error", error, 0);

        for (int i = 2; i < 8; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].p, 1'b1);
        end
        drain();
        check("table_error", error, 0);

        // Idle: bubbles only
        idle_mode = 1'b1;
        repeat (40) tick();
        idle_mode = 1'b0;
        check("idle_operand_nonzero", idle_op_bad, 0);
        check("idle_out_valid", idle_ov_bad, 0);
        check("idle_bubble_spacing", idle_bad, 0);
        check("idle_bubble_count_ge6", (idle_caps >= 6), 1);

        // Back-pressure: 4 results stored, 5th held, 6th refused
        out_ready = 1'b0;
        n0 = issue_cnt;
        for (int i = 0; i < 5; i++) begin
            send(32'h3F800000, kval[i], kval[i], 1'b1);
        end
        iss_q.push_back('{32'h3F800000, kval[5], kval[5]});
        out_q.push_back(kval[5]);
        in_a     = 32'h3F800000;
        in_b     = kval[5];
        in_valid = 1'b1;
        repeat (60) tick();
        check("bp_in_ready", in_ready, 0);
        check("bp_issued", issue_cnt - n0, 4);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        k = 0;
        while (!in_ready && k < 300) begin
            tick();
            k++;
        end
        check("bp_release_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        drain();

        // Watchdog: stall the multiplier after a real slot
        n0 = issue_cnt;
        send(32'h40000000, 32'h40800000, 32'h41000000, 1'b0);
        wait_issue(n0);
        mute = 1'b1;
        d = last_issue;
        send(32'h40400000, 32'h40400000, 32'h41100000, 1'b1);
        at_cycle(d + 17);
        check("wd_d17_error", error, 0);
        check("wd_d17_drop", drop_count, 0);
        at_cycle(d + 18);
        check("wd_d18_error", error, 1);
        check("wd_d18_drop", drop_count, 1);
        check("wd_d18_nreset", mul_nreset, 0);
        at_cycle(d + 19);
        check("wd_d19_nreset", mul_nreset, 0);
        mute = 1'b0;
        at_cycle(d + 20);
        check("wd_d20_nreset", mul_nreset, 1);
        drain();
        check("wd_drop_final", drop_count, 1);

        // Reset while waiting for a result
        n0 = issue_cnt;
        send(32'h40000000, 32'h40800000, 32'h41000000, 1'b0);
        wait_issue(n0);
        d = last_issue;
        at_cycle(d + 4);
        reset = 1'b1;
        at_cycle(d + 5);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_nreset", mul_nreset, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_error", error, 0);
        check("mid_rst_in_ready", in_ready, 0);
        reset = 1'b0;
        stale_mode = 1'b1;
        repeat (30) tick();
        stale_mode = 1'b0;
        check("mid_rst_stale", stale_cnt, 0);
        send(tbl[5].a, tbl[5].b, tbl[5].p, 1'b1);
        drain();
        check("final_iss_q_empty", iss_q.size(), 0);
        check("final_error", error, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
